// File: rtl/bcd_count_n_if.sv
// Control/status bundle for the N-digit BCD counter.
// Latency: none, wires only.
// Backpressure: none; the counter consumes control levels every cycle.
interface bcd_count_n_if #(
    parameter int DIGITS = 3,
    parameter int MAX_W  = 10
);
    logic                  run;
    logic                  tick;
    logic                  down;
    logic                  wrap;
    logic [MAX_W-1:0]      max_count;
    logic [4*DIGITS-1:0]   digits;
    logic [MAX_W-1:0]      count_bin;
    logic                  busy;
    logic                  done;
    logic                  wrap_pulse;

    // Controller side: drives run/tick/mode/limit, observes the count.
    modport master (
        output run, tick, down, wrap, max_count,
        input  digits, count_bin, busy, done, wrap_pulse
    );

    // Counter side.
    modport slave (
        input  run, tick, down, wrap, max_count,
        output digits, count_bin, busy, done, wrap_pulse
    );
endinterface

// File: rtl/bcd_count_n.sv
// N-digit up/down BCD counter with binary shadow, stop or wrap at a latched limit.
// Latency: all outputs registered; a qualified tick moves the count on the next edge.
// Backpressure: none; tick=0 simply holds the count, run=0 returns to IDLE.
module bcd_count_n #(
    parameter int DIGITS = 3,
    parameter int MAX_W  = 10
) (
    input  logic          clk,
    input  logic          rst,
    bcd_count_n_if.slave  bus
);
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int               CAP   = pow10(DIGITS) - 1;
    localparam logic [MAX_W-1:0] CAP_W = MAX_W'(CAP);
    localparam logic [MAX_W-1:0] ONE_W = MAX_W'(1);

    // Shift-add-3 conversion; the input is already clamped to CAP so it always fits.
    function automatic logic [4*DIGITS-1:0] bin2bcd(input logic [MAX_W-1:0] b);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
            end
            r = {r[4*DIGITS-2:0], b[i]};
        end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   digits_q, digits_d;
    logic [MAX_W-1:0]      bin_q, bin_d;
    logic [MAX_W-1:0]      max_lat;
    logic [4*DIGITS-1:0]   max_bcd;
    logic                  down_q, wrap_q;
    logic                  wrap_pulse_q, wrap_pulse_d;

    logic [MAX_W-1:0]      lim;
    logic [4*DIGITS-1:0]   lim_bcd;
    logic [MAX_W-1:0]      term_bin;
    logic                  at_term;
    logic [4*DIGITS-1:0]   bcd_inc, bcd_dec;
    logic                  carry, borrow;

    // Limit clamp is a plain binary compare; BCD form kept for the down-count reload.
    assign lim      = (bus.max_count > CAP_W) ? CAP_W : bus.max_count;
    assign lim_bcd  = bin2bcd(lim);
    assign term_bin = down_q ? '0 : max_lat;
    assign at_term  = (bin_q == term_bin);

    // Ripple +1 / -1 across the BCD digits, keeping every digit in 0..9.
    always_comb begin
        bcd_inc = digits_q;
        bcd_dec = digits_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (digits_q[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (digits_q[4*i +: 4] == 4'd0) begin
                    bcd_dec[4*i +: 4] = 4'd9;
                end else begin
                    bcd_dec[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Next state and next count; IDLE reloads from the value being latched this cycle.
    always_comb begin
        state_d      = state_q;
        digits_d     = digits_q;
        bin_d        = bin_q;
        wrap_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                digits_d = bus.down ? lim_bcd : '0;
                bin_d    = bus.down ? lim : '0;
                if (bus.run) state_d = COUNT;
            end
            COUNT: begin
                if (!bus.run) begin
                    state_d = IDLE;
                end else if (at_term && !wrap_q) begin
                    state_d = DONE;
                end else if (at_term) begin
                    if (bus.tick) begin
                        digits_d     = down_q ? max_bcd : '0;
                        bin_d        = down_q ? max_lat : '0;
                        wrap_pulse_d = 1'b1;
                    end
                end else if (bus.tick) begin
                    digits_d = down_q ? bcd_dec : bcd_inc;
                    bin_d    = down_q ? (bin_q - ONE_W) : (bin_q + ONE_W);
                end
            end
            DONE: begin
                if (!bus.run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Count, binary shadow and wrap pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q     <= '0;
            bin_q        <= '0;
            wrap_pulse_q <= 1'b0;
        end else begin
            digits_q     <= digits_d;
            bin_q        <= bin_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    // Limit and mode are sampled only while idle so mid-run changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_lat <= '0;
            max_bcd <= '0;
            down_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            max_lat <= lim;
            max_bcd <= lim_bcd;
            down_q  <= bus.down;
            wrap_q  <= bus.wrap;
        end
    end

    assign bus.digits     = digits_q;
    assign bus.count_bin  = bin_q;
    assign bus.busy       = (state_q == COUNT);
    assign bus.done       = (state_q == DONE);
    assign bus.wrap_pulse = wrap_pulse_q;
endmodule

// File: tb/tb_bcd_count_n.sv
module tb_bcd_count_n;
    localparam int DIGITS = 3;
    localparam int MAX_W  = 10;
    localparam int CAP    = 999;

    logic clk;
    logic rst;

    bcd_count_n_if #(.DIGITS(DIGITS), .MAX_W(MAX_W)) bus ();

    bcd_count_n #(.DIGITS(DIGITS), .MAX_W(MAX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference model state: 0 idle, 1 counting, 2 done.
    int m_state;
    int m_cnt;
    int m_max;
    int m_down;
    int m_wrap;
    int m_wp;

    typedef struct {
        logic run;
        logic tick;
        logic down;
        logic wrap;
        int   max;
        int   e_dig;
        int   e_bin;
        int   e_busy;
        int   e_done;
        int   e_wp;
    } vec_t;

    vec_t vt[22];

    function automatic int to_bcd(input int v);
        int r;
        int x;
        r = 0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | ((x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_max = 0; m_down = 0; m_wrap = 0; m_wp = 0;
    endtask

    // One clock of the counter's rules, evaluated on integers.
    task automatic model_step();
        int lim;
        int term;
        int start;
        lim = (int'(bus.max_count) > CAP) ? CAP : int'(bus.max_count);
        m_wp = 0;
        if (m_state == 0) begin
            m_max  = lim;
            m_down = int'(bus.down);
            m_wrap = int'(bus.wrap);
            m_cnt  = m_down ? m_max : 0;
            if (bus.run) m_state = 1;
        end else if (m_state == 1) begin
            term  = m_down ? 0 : m_max;
            start = m_down ? m_max : 0;
            if (!bus.run) m_state = 0;
            else if (m_cnt == term && m_wrap == 0) m_state = 2;
            else if (m_cnt == term) begin
                if (bus.tick) begin
                    m_cnt = start;
                    m_wp  = 1;
                end
            end else if (bus.tick) m_cnt = m_down ? m_cnt - 1 : m_cnt + 1;
        end else begin
            if (!bus.run) m_state = 0;
        end
    endtask

    task automatic compare_all();
        chk("digits",     int'(bus.digits),     to_bcd(m_cnt));
        chk("count_bin",  int'(bus.count_bin),  m_cnt);
        chk("busy",       int'(bus.busy),       (m_state == 1) ? 1 : 0);
        chk("done",       int'(bus.done),       (m_state == 2) ? 1 : 0);
        chk("wrap_pulse", int'(bus.wrap_pulse), m_wp);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic r, input logic t, input logic d, input logic w, input int m);
        bus.run       = r;
        bus.tick      = t;
        bus.down      = d;
        bus.wrap      = w;
        bus.max_count = MAX_W'(m);
    endtask

    initial begin
        int   pulses;
        int   prev;
        int   seen;
        int   dseen;
        int   found;
        total = 0;
        bad   = 0;
        model_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);

        // Reset state, sampled while reset is held.
        #12;
        chk("rst_digits", int'(bus.digits),     0);
        chk("rst_bin",    int'(bus.count_bin),  0);
        chk("rst_busy",   int'(bus.busy),       0);
        chk("rst_done",   int'(bus.done),       0);
        chk("rst_wp",     int'(bus.wrap_pulse), 0);
        #11 rst = 1'b0;

        // Directed vector table: each row is one clock.
        vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0,    3, 'h000,   0, 0, 0, 0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0,    3, 'h000,   0, 1, 0, 0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0,    9, 'h001,   1, 1, 0, 0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0,    9, 'h001,   1, 1, 0, 0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0,    9, 'h002,   2, 1, 0, 0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0,    9, 'h003,   3, 1, 0, 0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0,    9, 'h003,   3, 0, 1, 0};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b1,    9, 'h003,   3, 0, 1, 0};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0,   12, 'h003,   3, 0, 0, 0};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b0,   12, 'h012,  12, 0, 0, 0};
        vt[10] = '{1'b1, 1'b0, 1'b1, 1'b0,   12, 'h012,  12, 1, 0, 0};
        vt[11] = '{1'b1, 1'b1, 1'b1, 1'b0,   12, 'h011,  11, 1, 0, 0};
        vt[12] = '{1'b1, 1'b1, 1'b1, 1'b0,   12, 'h010,  10, 1, 0, 0};
        vt[13] = '{1'b1, 1'b1, 1'b1, 1'b0,   12, 'h009,   9, 1, 0, 0};
        vt[14] = '{1'b0, 1'b1, 1'b1, 1'b0,   12, 'h009,   9, 0, 0, 0};
        vt[15] = '{1'b0, 1'b0, 1'b0, 1'b1,    0, 'h000,   0, 0, 0, 0};
        vt[16] = '{1'b1, 1'b0, 1'b0, 1'b1,    0, 'h000,   0, 1, 0, 0};
        vt[17] = '{1'b1, 1'b1, 1'b0, 1'b1,    0, 'h000,   0, 1, 0, 1};
        vt[18] = '{1'b1, 1'b0, 1'b0, 1'b1,    0, 'h000,   0, 1, 0, 0};
        vt[19] = '{1'b1, 1'b1, 1'b0, 1'b1,    0, 'h000,   0, 1, 0, 1};
        vt[20] = '{1'b0, 1'b0, 1'b0, 1'b1,    0, 'h000,   0, 0, 0, 0};
        vt[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 1023, 'h999, 999, 0, 0, 0};

        @(posedge clk); #1;
        for (int i = 0; i < 22; i++) begin
            set_in(vt[i].run, vt[i].tick, vt[i].down, vt[i].wrap, vt[i].max);
            cycle();
            chk($sformatf("vec%0d_digits", i), int'(bus.digits),     vt[i].e_dig);
            chk($sformatf("vec%0d_bin", i),    int'(bus.count_bin),  vt[i].e_bin);
            chk($sformatf("vec%0d_busy", i),   int'(bus.busy),       vt[i].e_busy);
            chk($sformatf("vec%0d_done", i),   int'(bus.done),       vt[i].e_done);
            chk($sformatf("vec%0d_wp", i),     int'(bus.wrap_pulse), vt[i].e_wp);
        end

        // Up to 73 in stop mode; a limit change mid-run is ignored.
        set_in(0, 1, 0, 0, 73);
        cycle(); cycle();
        bus.run = 1'b1;
        for (int k = 0; k < 200 && !bus.done; k++) begin
            if (k == 15) bus.max_count = MAX_W'(15);
            cycle();
        end
        chk("t1_done",   int'(bus.done),      1);
        chk("t1_digits", int'(bus.digits),    'h073);
        chk("t1_bin",    int'(bus.count_bin), 73);
        cycle(); cycle(); cycle();
        chk("t1_held",   int'(bus.digits),    'h073);

        // Out-of-range limit clamps to 999.
        set_in(0, 1, 0, 0, 1023);
        cycle(); cycle();
        bus.run = 1'b1;
        for (int k = 0; k < 1100 && !bus.done; k++) cycle();
        chk("t2_digits", int'(bus.digits),    'h999);
        chk("t2_bin",    int'(bus.count_bin), 999);
        chk("t2_done",   int'(bus.done),      1);

        // Down from 25 in stop mode, through the 20 -> 19 borrow.
        set_in(0, 1, 1, 0, 25);
        cycle(); cycle();
        chk("t3_idle_digits", int'(bus.digits), 'h025);
        bus.run = 1'b1;
        seen = 0;
        prev = int'(bus.digits);
        for (int k = 0; k < 100 && !bus.done; k++) begin
            cycle();
            if (prev == 'h020 && int'(bus.digits) == 'h019) seen = 1;
            prev = int'(bus.digits);
        end
        chk("t3_borrow_seen", seen, 1);
        chk("t3_digits",      int'(bus.digits), 'h000);
        chk("t3_done",        int'(bus.done),   1);

        // Wrap mode, limit 15, tick on every third cycle.
        set_in(0, 0, 0, 1, 15);
        cycle(); cycle();
        bus.run = 1'b1;
        pulses = 0; seen = 0; dseen = 0;
        prev = int'(bus.digits);
        for (int k = 0; k < 160; k++) begin
            bus.tick = (k % 3 == 0);
            cycle();
            if (bus.wrap_pulse) pulses++;
            if (bus.done) dseen = 1;
            if (prev == 'h009 && int'(bus.digits) == 'h010) seen = 1;
            prev = int'(bus.digits);
        end
        chk("t4_carry_seen",   seen, 1);
        chk("t4_pulses_ge3",   (pulses >= 3) ? 1 : 0, 1);
        chk("t4_done_never",   dseen, 0);

        // Drop run at 40, reload from a new limit of 5.
        set_in(0, 1, 0, 0, 60);
        cycle(); cycle();
        bus.run = 1'b1;
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            cycle();
            if (int'(bus.digits) == 'h040) found = 1;
        end
        chk("t5_reached_40", found, 1);
        set_in(0, 1, 0, 0, 5);
        cycle();
        chk("t5_busy_off", int'(bus.busy), 0);
        cycle();
        chk("t5_reload",   int'(bus.digits), 'h000);
        bus.run = 1'b1;
        for (int k = 0; k < 50 && !bus.done; k++) cycle();
        chk("t5_digits",   int'(bus.digits), 'h005);
        chk("t5_done",     int'(bus.done),   1);

        // Asynchronous reset mid-count, asserted between clock edges.
        set_in(0, 1, 0, 0, 500);
        cycle(); cycle();
        bus.run = 1'b1;
        for (int k = 0; k < 20; k++) cycle();
        #3 rst = 1'b1;
        #1;
        chk("t6_digits", int'(bus.digits),    0);
        chk("t6_bin",    int'(bus.count_bin), 0);
        chk("t6_busy",   int'(bus.busy),      0);
        chk("t6_done",   int'(bus.done),      0);
        model_reset();
        bus.run = 1'b0;
        @(posedge clk); #1;
        chk("t6_hold", int'(bus.digits), 0);
        #2 rst = 1'b0;
        cycle();
        chk("t6_idle", int'(bus.busy), 0);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            bus.run  = ($urandom % 16) != 0;
            bus.tick = ($urandom % 3) != 0;
            bus.down = $urandom % 2;
            bus.wrap = $urandom % 2;
            bus.max_count = (($urandom % 4) == 0) ? MAX_W'($urandom_range(0, 1023))
                                                  : MAX_W'($urandom_range(0, 20));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
